pampy_stack_unit: RTL and testbench

PAMPY_STACK_UNIT -- requirements
Module: pampy_stack_unit

---
 rtl/pampy_stack_pkg.sv | 20 ++
 rtl/pampy_stack_if.sv | 33 +++
 rtl/pampy_stack_ram.sv | 31 +++
 rtl/pampy_stack_unit.sv | 173 +++++++++++++++++
 tb/tb_pampy_stack_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pampy_stack_pkg.sv
// Shared types for the pampy stack unit: command opcodes and controller states.
package pampy_stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_SWAP  = 3'd4,
        OP_BINOP = 3'd5,
        OP_OVER  = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/pampy_stack_if.sv
// Command/status bundle between a stack client (master) and the stack unit (slave).
interface pampy_stack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int PTR_WIDTH = $clog2(DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] tos_out;
    logic [DATA_WIDTH-1:0] nos_out;
    logic [PTR_WIDTH-1:0]  depth_out;
    logic                  empty;
    logic                  full;
    logic                  err_overflow;
    logic                  err_underflow;
    logic                  err_clear;

    modport master (
        output cmd_valid, cmd_op, cmd_data, err_clear,
        input  cmd_ready, tos_out, nos_out, depth_out, empty, full,
               err_overflow, err_underflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, err_clear,
        output cmd_ready, tos_out, nos_out, depth_out, empty, full,
               err_overflow, err_underflow
    );

endinterface

// File: rtl/pampy_stack_ram.sv
// Backing store for stack elements below NOS; synchronous write, registered read.
module pampy_stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH - 2)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH-2];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately left unreset; the controller never reads a slot it has not written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pampy_stack_unit.sv
// Hardware stack with TOS/NOS in registers and deeper elements spilled to RAM.
//   state     | meaning
//   ST_IDLE   | accepting commands, cmd_ready high
//   ST_REFILL | one cycle reloading NOS from RAM after a POP/BINOP
module pampy_stack_unit
    import pampy_stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic          clk,
    input  logic          reset,
    pampy_stack_if.slave  bus
);

    localparam int PTR_WIDTH = $clog2(DEPTH) + 1;
    localparam int RAM_AW    = $clog2(DEPTH - 2);

    typedef logic [PTR_WIDTH-1:0]  ptr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam ptr_t DEPTH_MAX = ptr_t'(DEPTH);
    localparam ptr_t ONE       = ptr_t'(1);
    localparam ptr_t TWO       = ptr_t'(2);
    localparam ptr_t THREE     = ptr_t'(3);

    state_e state_q, state_d;
    ptr_t   depth_q, depth_d;
    data_t  tos_q, tos_d;
    data_t  nos_q, nos_d;
    logic   ovf_q, ovf_d;
    logic   unf_q, unf_d;

    op_e    op;
    logic   accept;
    logic   ovf_set, unf_set;
    logic   push_en, pop_en;
    data_t  push_data;

    logic              ram_we, ram_re;
    logic [RAM_AW-1:0] ram_waddr, ram_raddr;
    data_t             ram_wdata, ram_rdata;

    assign op     = op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        push_data = bus.cmd_data;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = RAM_AW'(depth_q - TWO);
        ram_raddr = RAM_AW'(depth_q - THREE);
        ram_wdata = nos_q;

        if (state_q == ST_REFILL) begin
            nos_d   = ram_rdata;
            state_d = ST_IDLE;
        end else if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (depth_q == DEPTH_MAX) ovf_set = 1'b1;
                    else                      push_en = 1'b1;
                end
                OP_DUP: begin
                    push_data = tos_q;
                    if (depth_q == '0)             unf_set = 1'b1;
                    else if (depth_q == DEPTH_MAX) ovf_set = 1'b1;
                    else                           push_en = 1'b1;
                end
                OP_OVER: begin
                    push_data = nos_q;
                    if (depth_q < TWO)             unf_set = 1'b1;
                    else if (depth_q == DEPTH_MAX) ovf_set = 1'b1;
                    else                           push_en = 1'b1;
                end
                OP_POP: begin
                    if (depth_q == '0) begin
                        unf_set = 1'b1;
                    end else begin
                        tos_d  = nos_q;
                        pop_en = 1'b1;
                    end
                end
                OP_BINOP: begin
                    if (depth_q < TWO) begin
                        unf_set = 1'b1;
                    end else begin
                        tos_d  = bus.cmd_data;
                        pop_en = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (depth_q < TWO) begin
                        unf_set = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_CLEAR: depth_d = '0;
                default: ;
            endcase
        end

        if (push_en) begin
            ram_we  = (depth_q >= TWO);
            nos_d   = tos_q;
            tos_d   = push_data;
            depth_d = depth_q + ONE;
        end

        // NOS is left stale when nothing sits below it; the output mask hides it.
        if (pop_en) begin
            depth_d = depth_q - ONE;
            if (depth_q > TWO) begin
                ram_re  = 1'b1;
                state_d = ST_REFILL;
            end
        end

        ovf_d = (bus.err_clear ? 1'b0 : ovf_q) | ovf_set;
        unf_d = (bus.err_clear ? 1'b0 : unf_q) | unf_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    pampy_stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.cmd_ready     = (state_q == ST_IDLE);
    assign bus.tos_out       = (depth_q >= ONE) ? tos_q : '0;
    assign bus.nos_out       = (depth_q >= TWO) ? nos_q : '0;
    assign bus.depth_out     = depth_q;
    assign bus.empty         = (depth_q == '0);
    assign bus.full          = (depth_q == DEPTH_MAX);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;

endmodule

// File: tb/tb_pampy_stack_unit.sv
// Directed and randomized checks of pampy_stack_unit against a queue-based stack model.
module tb_pampy_stack_unit;
    import pampy_stack_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    pampy_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    pampy_stack_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] stk [$];
    bit            m_ovf, m_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_tos();
        return (stk.size() >= 1) ? stk[stk.size()-1] : '0;
    endfunction

    function automatic logic [DW-1:0] m_nos();
        return (stk.size() >= 2) ? stk[stk.size()-2] : '0;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".ready"}, 32'(bus.cmd_ready), 1);
        check_eq({tag, ".tos"},   32'(bus.tos_out), 32'(m_tos()));
        check_eq({tag, ".nos"},   32'(bus.nos_out), 32'(m_nos()));
        check_eq({tag, ".depth"}, 32'(bus.depth_out), stk.size());
        check_eq({tag, ".empty"}, 32'(bus.empty), 32'(stk.size() == 0));
        check_eq({tag, ".full"},  32'(bus.full), 32'(stk.size() == DEPTH));
        check_eq({tag, ".ovf"},   32'(bus.err_overflow), 32'(m_ovf));
        check_eq({tag, ".unf"},   32'(bus.err_underflow), 32'(m_unf));
    endtask

    // Stack semantics straight from the command definitions; returns whether a refill cycle follows.
    task automatic model_apply(input logic [2:0] op, input logic [DW-1:0] data, input bit clr,
                               output bit refill);
        int  d = stk.size();
        bit  o = 0, u = 0;
        logic [DW-1:0] t;
        refill = 0;
        case (op)
            3'd1: if (d == DEPTH) o = 1; else stk.push_back(data);
            3'd3: if (d == 0) u = 1; else if (d == DEPTH) o = 1; else stk.push_back(stk[d-1]);
            3'd6: if (d < 2) u = 1; else if (d == DEPTH) o = 1; else stk.push_back(stk[d-2]);
            3'd2: if (d == 0) u = 1; else begin void'(stk.pop_back()); refill = (d > 2); end
            3'd5: if (d < 2) u = 1; else begin
                void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(data); refill = (d > 2);
            end
            3'd4: if (d < 2) u = 1; else begin
                t = stk[d-1]; stk[d-1] = stk[d-2]; stk[d-2] = t;
            end
            3'd7: stk.delete();
            default: ;
        endcase
        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (o) m_ovf = 1;
        if (u) m_unf = 1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_ready", 32'(bus.cmd_ready), 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [DW-1:0] data, input bit clr);
        bit refill;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.err_clear = clr;
        @(posedge clk);
        model_apply(op, data, clr, refill);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.err_clear = 1'b0;
        if (refill) begin
            check_eq("refill.ready", 32'(bus.cmd_ready), 0);
            check_eq("refill.depth", 32'(bus.depth_out), stk.size());
            @(negedge clk);
        end
        check_state($sformatf("op%0d", op));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst.depth", 32'(bus.depth_out), 0);
        check_eq("rst.tos",   32'(bus.tos_out), 0);
        check_eq("rst.ready", 32'(bus.cmd_ready), 1);
        check_eq("rst.ovf",   32'(bus.err_overflow), 0);
        check_eq("rst.unf",   32'(bus.err_underflow), 0);
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_state("post_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = '0;
        bus.err_clear = 1'b0;

        apply_reset();

        // Three pushes, then pop with refill
        issue(3'd1, 8'h11, 0);
        issue(3'd1, 8'h22, 0);
        issue(3'd1, 8'h33, 0);
        check_eq("p3.tos",   32'(bus.tos_out), 32'h33);
        check_eq("p3.nos",   32'(bus.nos_out), 32'h22);
        check_eq("p3.depth", 32'(bus.depth_out), 3);
        check_eq("p3.ram0",  32'(dut.u_ram.mem_q[0]), 32'h11);
        issue(3'd2, 8'h00, 0);
        check_eq("pop.tos",   32'(bus.tos_out), 32'h22);
        check_eq("pop.nos",   32'(bus.nos_out), 32'h11);
        check_eq("pop.depth", 32'(bus.depth_out), 2);

        // Overflow on a full stack, then clear the flag
        issue(3'd7, 8'h00, 0);
        for (int i = 1; i <= 4; i++) issue(3'd1, 8'(i), 0);
        issue(3'd1, 8'h55, 0);
        check_eq("ovf.flag",  32'(bus.err_overflow), 1);
        check_eq("ovf.tos",   32'(bus.tos_out), 4);
        check_eq("ovf.depth", 32'(bus.depth_out), 4);
        issue(3'd0, 8'h00, 1);
        check_eq("ovf.clr", 32'(bus.err_overflow), 0);

        // BINOP with refill from RAM
        issue(3'd7, 8'h00, 0);
        issue(3'd1, 8'h03, 0);
        issue(3'd1, 8'h05, 0);
        issue(3'd1, 8'h07, 0);
        issue(3'd5, 8'h0C, 0);
        check_eq("binop.tos",   32'(bus.tos_out), 32'h0C);
        check_eq("binop.nos",   32'(bus.nos_out), 32'h03);
        check_eq("binop.depth", 32'(bus.depth_out), 2);

        // Underflow cases
        issue(3'd7, 8'h00, 0);
        issue(3'd1, 8'h09, 0);
        issue(3'd4, 8'h00, 0);
        check_eq("swap1.unf", 32'(bus.err_underflow), 1);
        check_eq("swap1.tos", 32'(bus.tos_out), 32'h09);
        issue(3'd2, 8'h00, 0);
        issue(3'd2, 8'h00, 0);
        check_eq("pop0.unf",   32'(bus.err_underflow), 1);
        check_eq("pop0.depth", 32'(bus.depth_out), 0);

        // Error raised in the same cycle as err_clear stays set
        issue(3'd2, 8'h00, 1);
        check_eq("clr_vs_set.unf", 32'(bus.err_underflow), 1);

        // Reset in the middle of a refill
        issue(3'd7, 8'h00, 1);
        issue(3'd1, 8'hA1, 0);
        issue(3'd1, 8'hA2, 0);
        issue(3'd1, 8'hA3, 0);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        check_eq("abort.in_refill", 32'(bus.cmd_ready), 0);
        reset = 1'b0;
        #1;
        check_eq("abort.depth", 32'(bus.depth_out), 0);
        check_eq("abort.tos",   32'(bus.tos_out), 0);
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        @(negedge clk);
        reset = 1'b1;
        check_state("abort.release");
        @(negedge clk);
        check_state("abort.settle");
        issue(3'd1, 8'hB0, 0);
        issue(3'd1, 8'hB1, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd1;
            if ($urandom_range(0, 99) == 0) apply_reset();
            issue(op, 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
